// File: rtl/cell_fetch.sv
// Streams one stored frame out of the cell cache, in ascending index order,
// through a 2-entry skid FIFO with ready/valid backpressure.
module cell_fetch #(
  parameter  int CELL_WIDTH  = 768,
  parameter  int CELL_NUM    = 1200,
  localparam int CELL_ADDR_W = $clog2(CELL_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cell_fetch_start_i,
  output logic                   cell_rd_en_o,
  output logic [CELL_ADDR_W-1:0] cell_rd_addr_o,
  input  logic [CELL_WIDTH-1:0]  cell_rd_data_i,
  output logic                   cell_valid_o,
  input  logic                   cell_ready_i,
  output logic [CELL_WIDTH-1:0]  cell_data_o,
  output logic [CELL_ADDR_W-1:0] cell_idx_o,
  output logic                   busy_o,
  output logic                   fetch_done_o
);

  // state | meaning
  // IDLE  | waiting for a stored frame
  // FETCH | issuing cache reads 0..CELL_NUM-1
  // DRAIN | all reads issued, emptying the FIFO
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [CELL_ADDR_W-1:0] LAST_ADDR = CELL_ADDR_W'(CELL_NUM - 1);

  state_t                 state, state_nxt;
  logic [CELL_ADDR_W-1:0] rd_addr;
  logic                   inflight;
  logic [CELL_ADDR_W-1:0] inflight_addr;
  logic                   start_pending, pending_nxt;
  logic                   clear_addr;

  logic [CELL_WIDTH-1:0]  fifo_data [2];
  logic [CELL_ADDR_W-1:0] fifo_idx  [2];
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             fifo_count;

  logic       pop, push, rd_en, last_rd, last_pop;
  logic [2:0] occ;

  assign pop      = cell_valid_o & cell_ready_i;
  assign push     = inflight;
  assign occ      = {1'b0, fifo_count} + {2'b00, inflight};
  // Reserve a FIFO slot for every outstanding read; a pop this cycle frees one.
  assign rd_en    = (state == FETCH) && (occ < (pop ? 3'd3 : 3'd2));
  assign last_rd  = rd_en && (rd_addr == LAST_ADDR);
  assign last_pop = pop && (cell_idx_o == LAST_ADDR);

  assign cell_rd_en_o   = rd_en;
  assign cell_rd_addr_o = rd_addr;
  assign cell_valid_o   = (fifo_count != 2'd0);
  assign cell_data_o    = fifo_data[rd_ptr];
  assign cell_idx_o     = fifo_idx[rd_ptr];
  assign busy_o         = (state != IDLE);
  assign fetch_done_o   = last_pop;

  always_comb begin
    state_nxt   = state;
    clear_addr  = 1'b0;
    pending_nxt = start_pending | (cell_fetch_start_i && (state != IDLE));
    case (state)
      IDLE: begin
        if (cell_fetch_start_i) begin
          state_nxt  = FETCH;
          clear_addr = 1'b1;
        end
      end
      FETCH: begin
        if (last_rd) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_pop) begin
          // A start arriving on the last handshake itself is honoured too.
          if (start_pending || cell_fetch_start_i) begin
            state_nxt   = FETCH;
            clear_addr  = 1'b1;
            pending_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      start_pending <= 1'b0;
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else begin
      state         <= state_nxt;
      start_pending <= pending_nxt;
      if (clear_addr)            rd_addr <= '0;
      else if (rd_en && !last_rd) rd_addr <= rd_addr + CELL_ADDR_W'(1);
      inflight <= rd_en;
      if (rd_en) inflight_addr <= rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_idx[i]  <= '0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= cell_rd_data_i;
        fifo_idx[wr_ptr]  <= inflight_addr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
